// File: rtl/axis_sel_pkg.sv
// axis_sel_pkg: shared encodings and helpers for the accelerometer axis display path.
package axis_sel_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO = 1'b1;
  typedef enum logic {ST_ACC, ST_CONV} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axis_sm_conv.sv
// axis_sm_conv: two's complement to saturating sign-magnitude converter.
module axis_sm_conv #(
  parameter int DW = 10
) (
  input  logic [DW-1:0] v,
  output logic [DW-1:0] sm
);
  logic [DW-1:0] n;
  always_comb begin
    n = -v;
    // The most negative input has no positive twin, so it clamps to full-scale magnitude.
    sm = !v[DW-1] ? v : {1'b1, (v[DW-2:0] == '0) ? {(DW-1){1'b1}} : n[DW-2:0]};
  end
endmodule

// File: rtl/axis_mag_select.sv
// axis_mag_select: per-channel windowed average with optional peak hold, shown as sign-magnitude.
module axis_mag_select
  import axis_sel_pkg::*;
#(
  parameter int NCH = 3,
  parameter int DW = 10,
  parameter int AVG_LOG2 = 0,
  parameter int DWELL = 4,
  parameter int SELW = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [SELW-1:0]   SEL,
  input  logic              MODE,
  input  logic              HOLD,
  input  logic [NCH*DW-1:0] DIN,
  input  logic              DIN_VLD,
  output logic [DW-1:0]     DOUT,
  output logic              DOUT_VLD,
  output logic [NCH-1:0]    LED
);
  localparam int CW = clog2(NCH);
  localparam int AW = DW + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam int WW = clog2(DWELL + 1);
  localparam logic [NW-1:0] WIN = NW'(1 << AVG_LOG2);
  localparam logic [WW-1:0] DWL = WW'(DWELL);
  localparam logic [SELW:0] NCHS = (SELW + 1)'(NCH);
  state_t state;
  logic [CW-1:0] ch, ch_nxt;
  logic mode_q, conv, adv, chg, take;
  logic signed [AW-1:0] acc, acc_base, smp_x;
  logic signed [DW-1:0] smp, avg;
  logic [NW-1:0] cnt, cnt_base, cnt_inc;
  logic [WW-1:0] dwell, dw_inc;
  logic [DW-2:0] pk;
  logic [DW-1:0] sm;
  always_comb begin
    conv = state == ST_CONV;
    dw_inc = dwell + 1'b1;
    adv = MODE == MODE_AUTO && conv && dw_inc >= DWL;
    ch_nxt = MODE == MODE_MANUAL ? (({1'b0, SEL} < NCHS) ? CW'(SEL) : '0)
           : adv ? ((ch == CW'(NCH - 1)) ? '0 : ch + 1'b1) : ch;
    chg = ch_nxt != ch || MODE != mode_q;
    // Sample from the incoming channel so a strobe coinciding with a switch opens the new window.
    smp = DIN[ch_nxt*DW +: DW];
    smp_x = AW'(smp);
    acc_base = (conv || chg) ? '0 : acc;
    cnt_base = (conv || chg) ? '0 : cnt;
    cnt_inc = cnt_base + 1'b1;
    avg = DW'(acc >>> AVG_LOG2);
    take = !HOLD || sm[DW-2:0] > pk;
  end
  axis_sm_conv #(.DW(DW)) u_conv (.v(avg), .sm(sm));
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_ACC;
      ch <= '0;
      mode_q <= MODE_MANUAL;
      acc <= '0;
      cnt <= '0;
      dwell <= '0;
      pk <= '0;
      DOUT <= '0;
      DOUT_VLD <= 1'b0;
      LED <= '0;
    end else begin
      ch <= ch_nxt;
      mode_q <= MODE;
      LED <= NCH'(1) << ch_nxt;
      acc <= DIN_VLD ? acc_base + smp_x : acc_base;
      cnt <= DIN_VLD ? cnt_inc : cnt_base;
      state <= (DIN_VLD && cnt_inc == WIN) ? ST_CONV : ST_ACC;
      dwell <= chg ? '0 : (conv && MODE == MODE_AUTO) ? dw_inc : dwell;
      DOUT_VLD <= conv;
      if (conv && take) DOUT <= sm;
      pk <= (chg || !HOLD) ? '0 : (conv && take) ? sm[DW-2:0] : pk;
    end
  end
endmodule

// File: tb/tb_axis_mag_select.sv
// tb_axis_mag_select: table-driven windows plus scan/reset sequences, checked through a result queue.
module tb_axis_mag_select;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sel = '0;
  logic mode = 1'b0;
  logic hold = 1'b0;
  logic [29:0] din = '0;
  logic din_vld = 1'b0;
  logic [9:0] dout;
  logic dout_vld;
  logic [2:0] led;
  int checks = 0;
  int failures = 0;
  logic [12:0] q[$];
  logic [12:0] e;
  logic [2:0] led_prev = '0;
  typedef struct {
    int sel;
    logic hold;
    int s0, s1, s2, s3;
    logic [9:0] dout;
    logic [2:0] led;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  axis_mag_select #(.NCH(3), .DW(10), .AVG_LOG2(2), .DWELL(2), .SELW(2)) dut (
    .CLK(clk), .RST(rst), .SEL(sel), .MODE(mode), .HOLD(hold), .DIN(din),
    .DIN_VLD(din_vld), .DOUT(dout), .DOUT_VLD(dout_vld), .LED(led)
  );

  // Each pulse consumes one queued result; LED is compared as it stood during the window's last cycle.
  always @(negedge clk) begin
    if (dout_vld) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL pulse: DOUT_VLD with DOUT=%h but no result was due", dout);
      end else begin
        e = q.pop_front();
        if (dout !== e[12:3] || led_prev !== e[2:0]) begin
          failures++;
          $display("FAIL result: DOUT=%h LED=%b, required DOUT=%h LED=%b", dout, led_prev, e[12:3], e[2:0]);
        end
      end
    end
    led_prev = led;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic put(input int c, input int val);
    for (int k = 0; k < 3; k++) din[k*10 +: 10] = (k == c) ? 10'(val) : 10'(100 + 37 * k);
  endtask

  function automatic vec_t mk(input int s, input logic h, input int a, input int b, input int c,
                              input int d, input logic [9:0] o, input logic [2:0] l);
    vec_t v;
    v.sel = s; v.hold = h; v.s0 = a; v.s1 = b; v.s2 = c; v.s3 = d; v.dout = o; v.led = l;
    return v;
  endfunction

  task automatic run_win(input vec_t v);
    int c;
    int sv[4];
    c = (v.sel < 3) ? v.sel : 0;
    sv[0] = v.s0; sv[1] = v.s1; sv[2] = v.s2; sv[3] = v.s3;
    sel = 2'(v.sel);
    hold = v.hold;
    for (int i = 0; i < 4; i++) begin
      put(c, sv[i]);
      din_vld = 1'b1;
      if (i == 3) q.push_back({v.dout, v.led});
      step();
    end
    din_vld = 1'b0;
    step();
    step();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d results still pending, required 0", name, q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      din = i[0] ? '1 : 30'h1555_5555;
      din_vld = i[0];
      step();
    end
    chk("rst_dout", 32'(dout), 0);
    chk("rst_vld", 32'(dout_vld), 0);
    chk("rst_led", 32'(led), 0);
    din_vld = 1'b0;
    rst = 1'b0;
    chk("led_before_edge", 32'(led), 0);
    step();
    chk("led_after_rst", 32'(led), 1);

    sel = 2'd2;
    put(2, 1);
    din_vld = 1'b1;
    step();
    put(2, 2);
    step();
    step();
    q.push_back({10'd1, 3'b100});
    step();
    din_vld = 1'b0;
    @(negedge clk);
    chk("lat_edge_n", 32'(dout_vld), 0);
    @(posedge clk);
    #1;
    chk("lat_edge_n1_vld", 32'(dout_vld), 1);
    chk("lat_edge_n1_dout", 32'(dout), 1);
    step();

    tbl.push_back(mk(1, 0, -3, -3, -3, -3, 10'h203, 3'b010));
    tbl.push_back(mk(3, 0, 5, 5, 5, 5, 10'h005, 3'b001));
    tbl.push_back(mk(0, 0, -512, -512, -512, -512, 10'h3FF, 3'b001));
    tbl.push_back(mk(2, 0, 511, 511, 511, 511, 10'h1FF, 3'b100));
    tbl.push_back(mk(2, 0, 1, 2, 2, 2, 10'h001, 3'b100));
    tbl.push_back(mk(2, 0, -1, -2, -2, -2, 10'h202, 3'b100));
    tbl.push_back(mk(0, 0, 0, 0, 0, -1, 10'h201, 3'b001));
    tbl.push_back(mk(1, 1, 5, 5, 5, 5, 10'h005, 3'b010));
    tbl.push_back(mk(1, 1, -9, -9, -9, -9, 10'h209, 3'b010));
    tbl.push_back(mk(1, 1, 3, 3, 3, 3, 10'h209, 3'b010));
    tbl.push_back(mk(1, 1, 9, 9, 9, 9, 10'h209, 3'b010));
    tbl.push_back(mk(1, 0, 2, 2, 2, 2, 10'h002, 3'b010));
    foreach (tbl[i]) run_win(tbl[i]);

    sel = 2'd1;
    put(1, 100);
    din_vld = 1'b1;
    step();
    step();
    run_win(mk(2, 0, 8, 8, 8, 8, 10'h008, 3'b100));
    drain("restart");

    sel = 2'd0;
    step();
    step();
    for (int k = 0; k < 3; k++) din[k*10 +: 10] = 10'(10 * (k + 1));
    for (int w = 0; w < 7; w++) q.push_back({10'(10 * ((w / 2) % 3 + 1)), 3'(1 << ((w / 2) % 3))});
    mode = 1'b1;
    step();
    din_vld = 1'b1;
    drain("auto_scan");
    step();
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_led", 32'(led), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    chk("mid_rst_vld", 32'(dout_vld), 0);
    q.delete();
    din[9:0] = 10'd40;
    step();
    rst = 1'b0;
    q.push_back({10'd40, 3'b001});
    q.push_back({10'd40, 3'b001});
    q.push_back({10'd20, 3'b010});
    drain("auto_after_rst");
    din_vld = 1'b0;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
